// File: rtl/aud_dsp_rate.sv
// aud_dsp_rate: variable-rate sample playback engine sitting between the SRAM
// reader and the I2S DAC serializer. One output sample per DAC LR-clock falling
// edge; fast mode skips F-1 samples, slow mode repeats or linearly interpolates.
// Optional feature macro: AUD_DSP_LOOP_EN (end of window restarts at the start
// address instead of returning to IDLE).
module aud_dsp_rate #(
    parameter int DW      = 16,
    parameter int AW      = 20,
    parameter int SPEED_W = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_pause,
    input  logic               i_stop,
    input  logic               i_fast,
    input  logic               i_interpolation,
    input  logic [SPEED_W-1:0] i_speed,
    input  logic [AW-1:0]      i_start_addr,
    input  logic [AW-1:0]      i_end_addr,
    input  logic               i_daclrck,
    input  logic [DW-1:0]      i_sram_data,
    output logic [AW-1:0]      o_sram_addr,
    output logic [DW-1:0]      o_dac_data,
    output logic               o_busy,
    output logic               o_done
);
    localparam int PW = DW + 1 + SPEED_W;   // |s1-s0| * k magnitude width
    localparam int FW = SPEED_W + 1;        // rate factor F = 1..2**SPEED_W
    localparam int CW = $clog2(PW + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PAUSE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RD0   = 3'd3,
        ST_RD1   = 3'd4,
        ST_CALC  = 3'd5,
        ST_OUT   = 3'd6
    } state_t;

    // Clamp a DW+2 bit signed value into the DW bit signed range.
    function automatic logic [DW-1:0] sat_fn(input logic [DW+1:0] v);
        logic [DW-1:0] r;
        if (!v[DW+1] && (v[DW] || v[DW-1])) begin
            r = {1'b0, {(DW-1){1'b1}}};
        end else if (v[DW+1] && !(v[DW] && v[DW-1])) begin
            r = {1'b1, {(DW-1){1'b0}}};
        end else begin
            r = v[DW-1:0];
        end
        return r;
    endfunction

    state_t               state_q, state_d;
    logic                 lrck_q;
    logic                 fast_q, fast_d, interp_q, interp_d;
    logic [SPEED_W-1:0]   speed_q, speed_d, k_q, k_d;
    logic [AW-1:0]        end_q, end_d, n_q, n_d, addr_q, addr_d;
`ifdef AUD_DSP_LOOP_EN
    logic [AW-1:0]        loop_addr_q, loop_addr_d;
`endif
    logic [DW-1:0]        s0_q, s0_d, dac_q, dac_d;
    logic                 pend_q, pend_d, done_q, done_d, busy_q, busy_d;
    logic [PW-1:0]        quo_q, quo_d;
    logic [FW-1:0]        rem_q, rem_d;
    logic                 neg_q, neg_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic                 event_s, ge_s, k_wrap_s, adv_s, eow_s;
    logic [FW-1:0]        f_s, rem_sh_s;
    logic [DW:0]          diff_s, diff_mag_s;
    logic [PW-1:0]        prod_s;
    logic [DW+1:0]        q_ext_s, sum_s;
    logic [DW-1:0]        val_s;
    logic [AW:0]          n_sum_s;
    logic [AW-1:0]        n1_s;

    // Datapath helpers: event detect, interpolation arithmetic, divider step, address advance.
    always_comb begin
        event_s    = lrck_q & ~i_daclrck;
        f_s        = {1'b0, speed_q} + {{SPEED_W{1'b0}}, 1'b1};
        diff_s     = {i_sram_data[DW-1], i_sram_data} - {s0_q[DW-1], s0_q};
        diff_mag_s = diff_s[DW] ? (~diff_s + {{DW{1'b0}}, 1'b1}) : diff_s;
        prod_s     = PW'(diff_mag_s) * PW'(k_q);
        rem_sh_s   = {rem_q[SPEED_W-1:0], quo_q[PW-1]};
        ge_s       = (rem_sh_s >= f_s);
        q_ext_s    = {1'b0, quo_q[DW:0]};
        if (neg_q) begin
            q_ext_s = ~q_ext_s + {{(DW+1){1'b0}}, 1'b1};
        end else begin
            q_ext_s = q_ext_s;
        end
        sum_s      = {{2{s0_q[DW-1]}}, s0_q} + q_ext_s;
        val_s      = (interp_q && !fast_q) ? sat_fn(sum_s) : s0_q;
        n1_s       = (n_q >= end_q) ? end_q : (n_q + {{(AW-1){1'b0}}, 1'b1});
        k_wrap_s   = (({1'b0, k_q} + {{SPEED_W{1'b0}}, 1'b1}) >= f_s);
        adv_s      = fast_q | k_wrap_s;
        if (fast_q) begin
            n_sum_s = {1'b0, n_q} + {{(AW+1-FW){1'b0}}, f_s};
        end else begin
            n_sum_s = {1'b0, n_q} + {{AW{1'b0}}, 1'b1};
        end
        eow_s      = adv_s & (n_sum_s[AW] | (n_sum_s[AW-1:0] > end_q));
    end

    // Playback FSM: next state, fetch/compute sequencing and output updates.
    always_comb begin
        state_d  = state_q;
        fast_d   = fast_q;
        interp_d = interp_q;
        speed_d  = speed_q;
        end_d    = end_q;
`ifdef AUD_DSP_LOOP_EN
        loop_addr_d = loop_addr_q;
`endif
        n_d      = n_q;
        k_d      = k_q;
        addr_d   = addr_q;
        s0_d     = s0_q;
        dac_d    = dac_q;
        pend_d   = pend_q;
        done_d   = 1'b0;
        quo_d    = quo_q;
        rem_d    = rem_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (event_s) begin
                    dac_d = {DW{1'b0}};
                end else begin
                    dac_d = dac_q;
                end
                if (i_start && !i_pause) begin
                    fast_d   = i_fast;
                    interp_d = i_interpolation;
                    speed_d  = i_speed;
                    end_d    = i_end_addr;
`ifdef AUD_DSP_LOOP_EN
                    loop_addr_d = i_start_addr;
`endif
                    n_d      = i_start_addr;
                    k_d      = {SPEED_W{1'b0}};
                    pend_d   = 1'b0;
                    state_d  = ST_WAIT;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_PAUSE: begin
                if (i_start && !i_pause) begin
                    fast_d   = i_fast;
                    interp_d = i_interpolation;
                    speed_d  = i_speed;
                    state_d  = ST_WAIT;
                end else begin
                    state_d  = ST_PAUSE;
                end
            end
            ST_WAIT: begin
                if (pend_q || i_pause) begin
                    dac_d   = {DW{1'b0}};
                    pend_d  = 1'b0;
                    state_d = ST_PAUSE;
                end else if (event_s) begin
                    addr_d  = n_q;
                    state_d = ST_RD0;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RD0: begin
                pend_d  = pend_q | i_pause;
                addr_d  = n1_s;
                state_d = ST_RD1;
            end
            ST_RD1: begin
                pend_d  = pend_q | i_pause;
                s0_d    = i_sram_data;
                cnt_d   = {CW{1'b0}};
                state_d = ST_CALC;
            end
            ST_CALC: begin
                pend_d = pend_q | i_pause;
                if (cnt_q == {CW{1'b0}}) begin
                    // s1 arrives this cycle; load the divider with |s1-s0|*k
                    if (interp_q && !fast_q) begin
                        quo_d = prod_s;
                        rem_d = {FW{1'b0}};
                        neg_d = diff_s[DW];
                        cnt_d = {{(CW-1){1'b0}}, 1'b1};
                    end else begin
                        state_d = ST_OUT;
                    end
                end else begin
                    quo_d = {quo_q[PW-2:0], ge_s};
                    rem_d = ge_s ? (rem_sh_s - f_s) : rem_sh_s;
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_q == CW'(PW)) begin
                        state_d = ST_OUT;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_OUT: begin
                pend_d = pend_q | i_pause;
                dac_d  = val_s;
                if (fast_q) begin
                    k_d = k_q;
                end else if (k_wrap_s) begin
                    k_d = {SPEED_W{1'b0}};
                end else begin
                    k_d = k_q + {{(SPEED_W-1){1'b0}}, 1'b1};
                end
                if (adv_s) begin
                    n_d = n_sum_s[AW-1:0];
                end else begin
                    n_d = n_q;
                end
                if (eow_s) begin
                    done_d  = 1'b1;
`ifdef AUD_DSP_LOOP_EN
                    n_d     = loop_addr_q;
                    k_d     = {SPEED_W{1'b0}};
                    state_d = ST_WAIT;
`else
                    pend_d  = 1'b0;
                    state_d = ST_IDLE;
`endif
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (i_stop) begin
            state_d = ST_IDLE;
            dac_d   = {DW{1'b0}};
            addr_d  = i_start_addr;
            pend_d  = 1'b0;
            done_d  = 1'b0;
        end else begin
            pend_d  = pend_d;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            lrck_q   <= 1'b0;
            fast_q   <= 1'b0;
            interp_q <= 1'b0;
            speed_q  <= {SPEED_W{1'b0}};
            end_q    <= {AW{1'b0}};
`ifdef AUD_DSP_LOOP_EN
            loop_addr_q <= {AW{1'b0}};
`endif
            n_q      <= {AW{1'b0}};
            k_q      <= {SPEED_W{1'b0}};
            addr_q   <= {AW{1'b0}};
            s0_q     <= {DW{1'b0}};
            dac_q    <= {DW{1'b0}};
            pend_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            quo_q    <= {PW{1'b0}};
            rem_q    <= {FW{1'b0}};
            neg_q    <= 1'b0;
            cnt_q    <= {CW{1'b0}};
        end else begin
            state_q  <= state_d;
            lrck_q   <= i_daclrck;
            fast_q   <= fast_d;
            interp_q <= interp_d;
            speed_q  <= speed_d;
            end_q    <= end_d;
`ifdef AUD_DSP_LOOP_EN
            loop_addr_q <= loop_addr_d;
`endif
            n_q      <= n_d;
            k_q      <= k_d;
            addr_q   <= addr_d;
            s0_q     <= s0_d;
            dac_q    <= dac_d;
            pend_q   <= pend_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_sram_addr = addr_q;
    assign o_dac_data  = dac_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
endmodule

// File: tb/tb_aud_dsp_rate.sv
// Testbench for aud_dsp_rate: the expected output stream of each playback
// window is computed up front from address/rate arithmetic into a queue;
// every DAC sample event pops one value and checks output, busy and done count.
module tb_aud_dsp_rate;
    localparam int AW   = 20;
    localparam int LOW  = 27;
    localparam int HIGH = 2;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        start = 1'b0, pause = 1'b0, stop = 1'b0;
    logic        fast = 1'b0, interp = 1'b0, lrck = 1'b1;
    logic [2:0]  speed = 3'd0;
    logic [19:0] saddr = 20'd0, eaddr = 20'd0;
    logic [15:0] sram_data = 16'h0000;
    logic [19:0] o_sram_addr;
    logic [15:0] o_dac_data;
    logic        o_busy, o_done;

    logic [15:0] mem [0:(1<<AW)-1];
    logic [15:0] exp_q [$];
    int checks = 0, errors = 0;
    int done_cnt = 0, exp_done = 0;
    int mstate = 0;            // 0 idle, 1 play, 2 pause
    bit loop_mode = 1'b0;

    aud_dsp_rate #(.DW(16), .AW(20), .SPEED_W(3)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_pause(pause), .i_stop(stop),
        .i_fast(fast), .i_interpolation(interp), .i_speed(speed),
        .i_start_addr(saddr), .i_end_addr(eaddr), .i_daclrck(lrck), .i_sram_data(sram_data),
        .o_sram_addr(o_sram_addr), .o_dac_data(o_dac_data), .o_busy(o_busy), .o_done(o_done)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) sram_data <= mem[o_sram_addr];

    always @(negedge clk) if (o_done === 1'b1) done_cnt++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic int sval(input longint a);
        logic [15:0] w;
        w = mem[int'(a)];
        return int'($signed(w));
    endfunction

    // Expected output stream of one full pass over the current window.
    function automatic void build_window();
        int f = int'(speed) + 1;
        longint e = longint'(eaddr);
        longint a1;
        int s0, s1, v;
        for (longint a = longint'(saddr); a <= e; a += (fast ? f : 1)) begin
            if (fast || !interp) begin
                for (int r = 0; r < (fast ? 1 : f); r++) exp_q.push_back(mem[int'(a)]);
            end else begin
                a1 = (a + 1 > e) ? e : a + 1;
                s0 = sval(a);
                s1 = sval(a1);
                for (int k = 0; k < f; k++) begin
                    v = s0 + ((s1 - s0) * k) / f;
                    if (v > 32767) v = 32767;
                    if (v < -32768) v = -32768;
                    exp_q.push_back(16'(v));
                end
            end
        end
    endfunction

    // One DAC sample event; optional pause pulse pause_at cycles into the low phase.
    task automatic ev(input int pause_at);
        logic [15:0] e;
        @(negedge clk) lrck = 1'b0;
        for (int c = 0; c < LOW; c++) begin
            if (c == pause_at) pause = 1'b1;
            @(negedge clk);
            pause = 1'b0;
        end
        e = 16'h0000;
        if (mstate == 1) begin
            e = exp_q.pop_front();
            if (exp_q.size() == 0) begin
                exp_done++;
                if (loop_mode) build_window();
                else mstate = 0;
            end
            if (pause_at >= 0 && mstate == 1) begin
                mstate = 2;
                e = 16'h0000;
            end
        end
        chk("dac", o_dac_data, e);
        chk("busy", o_busy, (mstate != 0));
        chk("done_count", done_cnt, exp_done);
        lrck = 1'b1;
        repeat (HIGH) @(negedge clk);
    endtask

    task automatic do_start(input bit f, input bit ip, input logic [2:0] sp,
                            input logic [19:0] s, input logic [19:0] e);
        @(negedge clk);
        fast = f; interp = ip; speed = sp; saddr = s; eaddr = e; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (mstate == 0) begin
            exp_q.delete();
            build_window();
            mstate = 1;
        end else if (mstate == 2) begin
            mstate = 1;
        end
    endtask

    task automatic do_stop(input logic [19:0] na, input bit with_start);
        @(negedge clk);
        saddr = na; stop = 1'b1; start = with_start;
        @(negedge clk);
        stop = 1'b0; start = 1'b0;
        mstate = 0;
        exp_q.delete();
        chk("stop_addr", o_sram_addr, na);
        chk("stop_busy", o_busy, 0);
        chk("stop_dac", o_dac_data, 0);
    endtask

    task automatic pulse_pause();
        @(negedge clk) pause = 1'b1;
        @(negedge clk) pause = 1'b0;
        if (mstate == 1) mstate = 2;
        chk("pause_dac", o_dac_data, 0);
        chk("pause_busy", o_busy, (mstate != 0));
    endtask

    initial begin
        int n;
        logic [19:0] rs;
`ifdef AUD_DSP_LOOP_EN
        loop_mode = 1'b1;
`else
        loop_mode = 1'b0;
`endif
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i);

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_addr", o_sram_addr, 0);
        chk("rst_dac", o_dac_data, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // normal play 0..1023 at x1
        do_start(1'b1, 1'b0, 3'd0, 20'd0, 20'd1023);
        chk("pin_x1_size", exp_q.size(), 1024);
        for (int i = 0; i < 1025; i++) ev(-1);
        do_stop(20'd0, 1'b0);

        // fast x4
        do_start(1'b1, 1'b0, 3'd3, 20'd0, 20'd1023);
        chk("pin_x4_size", exp_q.size(), 256);
        chk("pin_x4_last", exp_q[255], 16'd1020);
        for (int i = 0; i < 257; i++) ev(-1);
        do_stop(20'd0, 1'b0);

        // slow hold x3
        do_start(1'b0, 1'b0, 3'd2, 20'd0, 20'd7);
        for (int i = 0; i < 6; i++) chk("pin_hold", exp_q[i], (i < 3) ? 0 : 1);
        for (int i = 0; i < 25; i++) ev(-1);
        do_stop(20'd0, 1'b0);

        // slow linear x4, rising
        mem[0] = 16'h0000; mem[1] = 16'h0100;
        do_start(1'b0, 1'b1, 3'd3, 20'd0, 20'd1);
        chk("pin_lin0", exp_q[1], 16'h0040);
        chk("pin_lin1", exp_q[3], 16'h00C0);
        chk("pin_lin2", exp_q[4], 16'h0100);
        for (int i = 0; i < 9; i++) ev(-1);
        do_stop(20'd0, 1'b0);

        // slow linear x2, falling step of -0x80
        mem[0] = 16'h0100; mem[1] = 16'h0000;
        do_start(1'b0, 1'b1, 3'd1, 20'd0, 20'd1);
        chk("pin_neg", exp_q[1], 16'h0080);
        for (int i = 0; i < 5; i++) ev(-1);
        do_stop(20'd0, 1'b0);

        // truncation toward zero: (-1 * k) / 3 == 0
        mem[0] = 16'h0000; mem[1] = 16'hFFFF;
        do_start(1'b0, 1'b1, 3'd2, 20'd0, 20'd1);
        chk("pin_trunc", exp_q[2], 16'h0000);
        for (int i = 0; i < 7; i++) ev(-1);
        do_stop(20'd0, 1'b0);

        // pause / resume / pause in flight / stop+start
        for (int i = 100; i < 200; i++) mem[i] = 16'($urandom);
        do_start(1'b1, 1'b0, 3'd0, 20'd100, 20'd199);
        for (int i = 0; i < 6; i++) ev(-1);
        pulse_pause();
        for (int i = 0; i < 10; i++) ev(-1);
        do_start(1'b1, 1'b0, 3'd0, 20'd100, 20'd199);
        chk("pin_resume", exp_q[0], mem[106]);
        for (int i = 0; i < 4; i++) ev(-1);
        ev(3);
        for (int i = 0; i < 2; i++) ev(-1);
        do_start(1'b1, 1'b0, 3'd0, 20'd100, 20'd199);
        for (int i = 0; i < 2; i++) ev(-1);
        do_stop(20'd55, 1'b1);
        ev(-1);

        // window 8..11 (loops when the loop feature is built)
        for (int i = 8; i < 12; i++) mem[i] = 16'(i);
        do_start(1'b1, 1'b0, 3'd0, 20'd8, 20'd11);
        for (int i = 0; i < 10; i++) ev(-1);
        do_stop(20'd8, 1'b0);

        // address wrap at top of SRAM
        for (int i = (1<<AW)-3; i < (1<<AW); i++) mem[i] = 16'($urandom);
        do_start(1'b1, 1'b0, 3'd3, 20'hFFFFD, 20'hFFFFF);
        chk("pin_wrap_size", exp_q.size(), 1);
        for (int i = 0; i < 2; i++) ev(-1);
        do_stop(20'd0, 1'b0);

        // randomized windows and modes
        for (int r = 0; r < 6; r++) begin
            rs = 20'($urandom_range(0, (1<<AW) - 64));
            n  = $urandom_range(1, 10);
            for (int i = 0; i < n; i++) mem[int'(rs) + i] = 16'($urandom);
            do_start(1'($urandom), 1'($urandom), 3'($urandom), rs, rs + 20'(n - 1));
            n = exp_q.size() + 1;
            for (int i = 0; i < n; i++) ev(-1);
            do_stop(rs, 1'b0);
        end

        // asynchronous reset in the middle of the interpolation divide
        mem[0] = 16'h1234; mem[1] = 16'h4321;
        do_start(1'b0, 1'b1, 3'd7, 20'd0, 20'd1);
        ev(-1);
        @(negedge clk) lrck = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_dac", o_dac_data, 0);
        chk("arst_addr", o_sram_addr, 0);
        chk("arst_busy", o_busy, 0);
        chk("arst_done", o_done, 0);
        @(negedge clk) rst_n = 1'b1;
        mstate = 0;
        exp_q.delete();
        lrck = 1'b1;
        repeat (3) @(negedge clk);
        ev(-1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
